// File: rtl/mips_pipe_pkg.sv
// Shared constants and helpers for the elastic inter-stage pipeline.
// Popcount feeds the optional flush counter (PIPE_PERF_CNT_EN).
package mips_pipe_pkg;

  localparam logic [31:0] MIPS_NOP  = 32'h0000_0000;
  localparam int          MAX_DEPTH = 8;

  function automatic logic [3:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mips_elastic_pipe_slot.sv
// One pipeline slot: a valid bit plus a payload register.
// Flush beats load and hold; an invalid source loads NOP_VALUE.
module pipe_slot
  import mips_pipe_pkg::*;
#(
  parameter int              DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else if (load) begin
      valid_q <= src_valid;
      data_q  <= src_valid ? src_data : NOP_VALUE;
    end
  end

endmodule

// File: rtl/mips_elastic_pipe.sv
// Elastic DEPTH-slot pipeline with valid/ready, stall, flush, bubble collapse.
// Optional performance counters under `PIPE_PERF_CNT_EN.
module mips_elastic_pipe
  import mips_pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_Valid,
  input  logic [DATA_W-1:0] in_Data_dw,
  output logic              o_Ready,
  input  logic              in_Ready,
  output logic              o_Valid,
  output logic [DATA_W-1:0] o_Data_dw,
  input  logic              in_Stall,
  input  logic [DEPTH-1:0]  in_Flush_dw,
  output logic [DEPTH-1:0]  o_StageValid_dw
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_StallCycles_dw,
  output logic [CNT_W-1:0]  o_BubbleCycles_dw,
  output logic [CNT_W-1:0]  o_FlushCount_dw
`endif
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("DEPTH out of range");
  end

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  src_v;
  logic [DATA_W-1:0] src_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Ready ripples from the output back to slot 0, so empty slots
  // absorb items even while later slots are blocked.
  always_comb begin
    logic r;
    rdy = '0;
    r   = in_Ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = (~valid_q[i] | r) & ~in_Stall;
      r      = rdy[i];
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_Valid;
    src_d[0] = in_Data_dw;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = valid_q[i-1];
      src_d[i] = data_q[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    pipe_slot #(
      .DATA_W    (DATA_W),
      .NOP_VALUE (NOP_VALUE)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (rdy[i]),
      .flush     (in_Flush_dw[i]),
      .src_valid (src_v[i]),
      .src_data  (src_d[i]),
      .valid_q   (valid_q[i]),
      .data_q    (data_q[i])
    );
  end

  assign o_Ready         = rdy[0] & ~reset;
  assign o_Valid         = valid_q[DEPTH-1] & ~in_Stall;
  assign o_Data_dw       = data_q[DEPTH-1];
  assign o_StageValid_dw = valid_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W:0]   flush_sum;

  assign flush_sum = {1'b0, flush_cnt}
    + (CNT_W+1)'(popcount(MAX_DEPTH'(in_Flush_dw & valid_q)));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (in_Stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (!in_Stall && !valid_q[DEPTH-1] && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
      flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end

  assign o_StallCycles_dw  = stall_cnt;
  assign o_BubbleCycles_dw = bubble_cnt;
  assign o_FlushCount_dw   = flush_cnt;
`endif

endmodule

// File: tb/tb_mips_elastic_pipe.sv
// Directed self-checking bench for mips_elastic_pipe, DEPTH=3, DATA_W=8.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mips_elastic_pipe;

  localparam int         DW  = 8;
  localparam int         DP  = 3;
  localparam logic [7:0] NOP = 8'h00;

  logic          clk;
  logic          reset;
  logic          in_Valid;
  logic [DW-1:0] in_Data_dw;
  logic          o_Ready;
  logic          in_Ready;
  logic          o_Valid;
  logic [DW-1:0] o_Data_dw;
  logic          in_Stall;
  logic [DP-1:0] in_Flush_dw;
  logic [DP-1:0] o_StageValid_dw;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   o_StallCycles_dw;
  logic [31:0]   o_BubbleCycles_dw;
  logic [31:0]   o_FlushCount_dw;
`endif

  int checks;
  int fails;

  mips_elastic_pipe #(
    .DATA_W    (DW),
    .DEPTH     (DP),
    .NOP_VALUE (NOP),
    .CNT_W     (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_Valid        (in_Valid),
    .in_Data_dw      (in_Data_dw),
    .o_Ready         (o_Ready),
    .in_Ready        (in_Ready),
    .o_Valid         (o_Valid),
    .o_Data_dw       (o_Data_dw),
    .in_Stall        (in_Stall),
    .in_Flush_dw     (in_Flush_dw),
    .o_StageValid_dw (o_StageValid_dw)
`ifdef PIPE_PERF_CNT_EN
    ,
    .o_StallCycles_dw  (o_StallCycles_dw),
    .o_BubbleCycles_dw (o_BubbleCycles_dw),
    .o_FlushCount_dw   (o_FlushCount_dw)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push 33, 22, 11 into an empty pipe with no downstream ready.
  task automatic fill3();
    logic [7:0] v [3];
    v = '{8'h33, 8'h22, 8'h11};
    in_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_Valid   = 1'b1;
      in_Data_dw = v[i];
      step();
    end
    in_Valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_Valid = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", o_Ready); end
    checks++; if (o_StageValid_dw !== 3'b000) begin fails++; $display("FAIL rst_stage got %b exp 000", o_StageValid_dw); end
    checks++; if (o_Valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", o_Valid); end
    checks++; if (o_Data_dw !== NOP) begin fails++; $display("FAIL rst_data got %h exp %h", o_Data_dw, NOP); end
    step();
    reset = 1'b0;
    in_Valid = 1'b0;
    @(negedge clk);
    checks++; if (o_Ready !== 1'b1) begin fails++; $display("FAIL rst_rel_ready got %b exp 1", o_Ready); end
    step();
  endtask

  task automatic test_stream();
    logic [7:0] v [3];
    v = '{8'h11, 8'h22, 8'h33};
    in_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_Valid   = 1'b1;
      in_Data_dw = v[i];
      @(negedge clk);
      checks++; if (o_Ready !== 1'b1) begin fails++; $display("FAIL stream_ready%0d got %b exp 1", i, o_Ready); end
      checks++; if (o_Valid !== 1'b0) begin fails++; $display("FAIL stream_early%0d got %b exp 0", i, o_Valid); end
      step();
    end
    in_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (o_Valid !== 1'b1) begin fails++; $display("FAIL stream_valid%0d got %b exp 1", i, o_Valid); end
      checks++; if (o_Data_dw !== v[i]) begin fails++; $display("FAIL stream_data%0d got %h exp %h", i, o_Data_dw, v[i]); end
      step();
    end
    @(negedge clk);
    checks++; if (o_Valid !== 1'b0) begin fails++; $display("FAIL stream_end got %b exp 0", o_Valid); end
    step();
  endtask

  task automatic test_backpressure();
    fill3();
    @(negedge clk);
    checks++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL bp_ready got %b exp 0", o_Ready); end
    checks++; if (o_StageValid_dw !== 3'b111) begin fails++; $display("FAIL bp_stage got %b exp 111", o_StageValid_dw); end
    checks++; if (o_Data_dw !== 8'h33) begin fails++; $display("FAIL bp_data got %h exp 33", o_Data_dw); end
    step();
    in_Ready = 1'b1;
    @(negedge clk);
    checks++; if (o_Ready !== 1'b1) begin fails++; $display("FAIL bp_ready_same got %b exp 1", o_Ready); end
    step();
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b110) begin fails++; $display("FAIL bp_shift_stage got %b exp 110", o_StageValid_dw); end
    checks++; if (o_Data_dw !== 8'h22) begin fails++; $display("FAIL bp_shift_d0 got %h exp 22", o_Data_dw); end
    step();
    @(negedge clk);
    checks++; if (o_Data_dw !== 8'h11) begin fails++; $display("FAIL bp_shift_d1 got %h exp 11", o_Data_dw); end
    step();
  endtask

  task automatic test_bubble_collapse();
    in_Ready   = 1'b0;
    in_Valid   = 1'b1;
    in_Data_dw = 8'h33;
    step();
    in_Valid = 1'b0;
    step();
    step();
    in_Valid   = 1'b1;
    in_Data_dw = 8'h11;
    step();
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b101) begin fails++; $display("FAIL bub_setup got %b exp 101", o_StageValid_dw); end
    in_Data_dw = 8'h44;
    checks++; if (o_Ready !== 1'b1) begin fails++; $display("FAIL bub_ready got %b exp 1", o_Ready); end
    step();
    in_Valid = 1'b0;
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b111) begin fails++; $display("FAIL bub_stage got %b exp 111", o_StageValid_dw); end
    step();
    in_Ready = 1'b1;
    @(negedge clk);
    checks++; if (o_Data_dw !== 8'h33) begin fails++; $display("FAIL bub_d0 got %h exp 33", o_Data_dw); end
    step();
    @(negedge clk);
    checks++; if (o_Data_dw !== 8'h11) begin fails++; $display("FAIL bub_d1 got %h exp 11", o_Data_dw); end
    step();
    @(negedge clk);
    checks++; if (o_Data_dw !== 8'h44) begin fails++; $display("FAIL bub_d2 got %h exp 44", o_Data_dw); end
    step();
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b000) begin fails++; $display("FAIL bub_empty got %b exp 000", o_StageValid_dw); end
  endtask

  task automatic test_flush();
    fill3();
    in_Ready    = 1'b1;
    in_Flush_dw = 3'b011;
    @(negedge clk);
    checks++; if (o_Valid !== 1'b1 || o_Data_dw !== 8'h33) begin fails++; $display("FAIL fl_emit got %b/%h exp 1/33", o_Valid, o_Data_dw); end
    step();
    in_Flush_dw = 3'b000;
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b100) begin fails++; $display("FAIL fl_stage got %b exp 100", o_StageValid_dw); end
    checks++; if (o_Data_dw !== 8'h22) begin fails++; $display("FAIL fl_move got %h exp 22", o_Data_dw); end
    step();
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b000) begin fails++; $display("FAIL fl_drain got %b exp 000", o_StageValid_dw); end
    checks++; if (o_Data_dw !== NOP) begin fails++; $display("FAIL fl_nop got %h exp %h", o_Data_dw, NOP); end
    step();
  endtask

  task automatic test_stall();
    fill3();
    in_Ready   = 1'b1;
    in_Stall   = 1'b1;
    in_Valid   = 1'b1;
    in_Data_dw = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL st_ready%0d got %b exp 0", i, o_Ready); end
      checks++; if (o_Valid !== 1'b0) begin fails++; $display("FAIL st_valid%0d got %b exp 0", i, o_Valid); end
      checks++; if (o_StageValid_dw !== 3'b111 || o_Data_dw !== 8'h33) begin fails++; $display("FAIL st_hold%0d got %b/%h exp 111/33", i, o_StageValid_dw, o_Data_dw); end
      step();
    end
    in_Flush_dw = 3'b100;
    step();
    in_Flush_dw = 3'b000;
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b011 || o_Data_dw !== NOP) begin fails++; $display("FAIL st_flush got %b/%h exp 011/00", o_StageValid_dw, o_Data_dw); end
    step();
    in_Stall = 1'b0;
    in_Valid = 1'b0;
    in_Ready = 1'b0;
    @(negedge clk);
    checks++; if (o_Ready !== 1'b1) begin fails++; $display("FAIL st_release got %b exp 1", o_Ready); end
    step();
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b110 || o_Data_dw !== 8'h22) begin fails++; $display("FAIL st_resume got %b/%h exp 110/22", o_StageValid_dw, o_Data_dw); end
  endtask

  task automatic test_reset_midstream();
    in_Ready   = 1'b0;
    in_Valid   = 1'b1;
    in_Data_dw = 8'h66;
    step();
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b111) begin fails++; $display("FAIL mr_full got %b exp 111", o_StageValid_dw); end
    reset = 1'b1;
    #1;
    checks++; if (o_Ready !== 1'b0) begin fails++; $display("FAIL mr_ready got %b exp 0", o_Ready); end
    step();
    reset    = 1'b0;
    in_Valid = 1'b0;
    @(negedge clk);
    checks++; if (o_StageValid_dw !== 3'b000) begin fails++; $display("FAIL mr_stage got %b exp 000", o_StageValid_dw); end
    checks++; if (o_Data_dw !== NOP || o_Valid !== 1'b0) begin fails++; $display("FAIL mr_out got %b/%h exp 0/00", o_Valid, o_Data_dw); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (o_StallCycles_dw !== 32'd0) begin fails++; $display("FAIL mr_stallcnt got %0d exp 0", o_StallCycles_dw); end
    checks++; if (o_BubbleCycles_dw !== 32'd0) begin fails++; $display("FAIL mr_bubcnt got %0d exp 0", o_BubbleCycles_dw); end
    checks++; if (o_FlushCount_dw !== 32'd0) begin fails++; $display("FAIL mr_flcnt got %0d exp 0", o_FlushCount_dw); end
`endif
    step();
  endtask

  initial begin
    checks      = 0;
    fails       = 0;
    reset       = 1'b1;
    in_Valid    = 1'b0;
    in_Data_dw  = '0;
    in_Ready    = 1'b0;
    in_Stall    = 1'b0;
    in_Flush_dw = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_stall();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
